// File: rtl/sequencer_if.sv
// Sequencer bus: program fetch, flag input and execution control/status outputs.
interface sequencer_if #(
  parameter int unsigned PcW   = 8,
  parameter int unsigned InstW = 15
) ();

  logic             run;
  logic [InstW-1:0] prom_out;
  logic             cmp_eq;
  logic [PcW-1:0]   p_count;
  logic [InstW-1:0] ir;
  logic [2:0]       phase;
  logic             reg_we;
  logic             mem_we;
  logic             flag_we;
  logic             halted;
  logic [15:0]      inst_cnt;

  // Sequencer side.
  modport master (
    input  run, prom_out, cmp_eq,
    output p_count, ir, phase, reg_we, mem_we, flag_we, halted, inst_cnt
  );

  // Environment side: fetch unit, ALU flag and run control.
  modport slave (
    output run, prom_out, cmp_eq,
    input  p_count, ir, phase, reg_we, mem_we, flag_we, halted, inst_cnt
  );

endinterface

// File: rtl/sequencer.sv
// Instruction sequencer: owns the PC, latches the fetched word into IR and
// steps each instruction through FETCH/DECODE/EXEC/WB with WB-only strobes.
module sequencer #(
  parameter int unsigned PcW   = 8,
  parameter int unsigned InstW = 15
) (
  input logic         clk_sq,
  input logic         reset,
  sequencer_if.master bus
);

  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } phase_e;

  typedef enum logic [3:0] {
    OpMov = 4'h0,
    OpAdd = 4'h1,
    OpSub = 4'h2,
    OpAnd = 4'h3,
    OpOr  = 4'h4,
    OpSl  = 4'h5,
    OpSr  = 4'h6,
    OpSra = 4'h7,
    OpLdl = 4'h8,
    OpLdh = 4'h9,
    OpCmp = 4'hA,
    OpJe  = 4'hB,
    OpJmp = 4'hC,
    OpLd  = 4'hD,
    OpSt  = 4'hE,
    OpHlt = 4'hF
  } opcode_e;

  phase_e           state_q;
  logic [PcW-1:0]   pc_q;
  logic [InstW-1:0] ir_q;
  logic             reg_we_q;
  logic             mem_we_q;
  logic             flag_we_q;
  logic             halted_q;
  logic [CntW-1:0]  inst_cnt_q;

  opcode_e        op;
  logic [PcW-1:0] target;
  logic [PcW-1:0] pc_inc;
  logic [PcW-1:0] pc_next;
  logic           wr_reg;
  logic           wr_mem;
  logic           wr_flag;

  assign op     = opcode_e'(ir_q[InstW-1 -: 4]);
  assign target = ir_q[PcW-1:0];
  // Natural wrap at the top of the address space.
  assign pc_inc = pc_q + PcW'(1);

  // Decode which write strobe the instruction in IR raises during WB.
  always_comb begin
    wr_reg  = 1'b0;
    wr_mem  = 1'b0;
    wr_flag = 1'b0;
    unique case (op)
      OpMov, OpAdd, OpSub, OpAnd, OpOr, OpSl, OpSr, OpSra, OpLdl, OpLdh, OpLd: wr_reg = 1'b1;
      OpSt:                wr_mem  = 1'b1;
      OpCmp:               wr_flag = 1'b1;
      OpJe, OpJmp, OpHlt:  begin end
    endcase
  end

  // PC value taken at the WB exit edge; je looks at the flag as seen in WB.
  always_comb begin
    pc_next = pc_inc;
    case (op)
      OpJmp:   pc_next = target;
      OpJe:    if (bus.cmp_eq) pc_next = target;
      OpHlt:   pc_next = pc_q;
      default: pc_next = pc_inc;
    endcase
  end

  // Phase FSM with registered strobes, PC, IR and retired-instruction count.
  always_ff @(posedge clk_sq or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      reg_we_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      flag_we_q  <= 1'b0;
      halted_q   <= 1'b0;
      inst_cnt_q <= '0;
    end else begin
      // Strobes are pulses; only the EXEC->WB transition raises them.
      reg_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      flag_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.run) state_q <= StFetch;
        end
        StFetch: begin
          state_q <= StDecode;
        end
        StDecode: begin
          // The fetch unit's word is valid in DECODE.
          ir_q    <= bus.prom_out;
          state_q <= StExec;
        end
        StExec: begin
          reg_we_q  <= wr_reg;
          mem_we_q  <= wr_mem;
          flag_we_q <= wr_flag;
          state_q   <= StWb;
        end
        StWb: begin
          pc_q       <= pc_next;
          inst_cnt_q <= inst_cnt_q + CntW'(1);
          if (op == OpHlt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (bus.run) begin
            state_q <= StFetch;
          end else begin
            state_q <= StIdle;
          end
        end
        StHalt: begin
          // Terminal until reset.
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.p_count  = pc_q;
  assign bus.ir       = ir_q;
  assign bus.phase    = state_q;
  assign bus.reg_we   = reg_we_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.flag_we  = flag_we_q;
  assign bus.halted   = halted_q;
  assign bus.inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: per-cycle expectations are queued as each
// program is launched and checked one per cycle on the falling clock edge.
module tb_sequencer;

  logic clk;
  logic reset;
  logic cmp_result;
  logic [14:0] rom [256];

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic [2:0]  phase;
    logic [2:0]  stb;     // {reg_we, mem_we, flag_we}
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  sequencer_if bus ();

  sequencer dut (
    .clk_sq (clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: word for P_COUNT appears the cycle after FETCH.
  always @(posedge clk) bus.prom_out <= rom[bus.p_count];

  // Compare-flag register, written on the cmp WB strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) bus.cmp_eq <= 1'b0;
    else if (bus.flag_we) bus.cmp_eq <= cmp_result;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_state(input string tag, input logic [2:0] ph, input logic [7:0] pc,
                            input logic [15:0] cnt, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag; e.phase = ph; e.stb = 3'b000; e.halted = (ph == 3'd5);
      e.pc = pc; e.cnt = cnt;
      sb.push_back(e);
    end
  endtask

  // One instruction: FETCH, DECODE, EXEC with no strobes, then WB with stb.
  task automatic push_instr(input string tag, input logic [2:0] stb, input logic [7:0] pc,
                            input logic [15:0] cnt);
    exp_t e;
    for (int p = 1; p <= 4; p++) begin
      e.tag = $sformatf("%s.p%0d", tag, p); e.phase = 3'(p);
      e.stb = (p == 4) ? stb : 3'b000; e.halted = 1'b0; e.pc = pc; e.cnt = cnt;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_empty: observed 0 entries expected at least 1");
      end else begin
        e = sb.pop_front();
        check({e.tag, ".phase"},  32'(bus.phase), 32'(e.phase));
        check({e.tag, ".stb"},    32'({bus.reg_we, bus.mem_we, bus.flag_we}), 32'(e.stb));
        check({e.tag, ".halted"}, 32'(bus.halted), 32'(e.halted));
        check({e.tag, ".pc"},     32'(bus.p_count), 32'(e.pc));
        check({e.tag, ".cnt"},    32'(bus.inst_cnt), 32'(e.cnt));
      end
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 15'h7800;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cmp_result  = 1'b0;
    bus.run     = 1'b0;
    reset       = 1'b1;
    fill_rom();
    #1;
    check("rst.phase",  32'(bus.phase), 32'd0);
    check("rst.pc",     32'(bus.p_count), 32'd0);
    check("rst.ir",     32'(bus.ir), 32'd0);
    check("rst.stb",    32'({bus.reg_we, bus.mem_we, bus.flag_we}), 32'd0);
    check("rst.halted", 32'(bus.halted), 32'd0);
    check("rst.cnt",    32'(bus.inst_cnt), 32'd0);

    // Reset and run: mov, add, hlt.
    rom[0] = 15'h0000; rom[1] = 15'h0800; rom[2] = 15'h7800;
    do_reset();
    bus.run = 1'b1;
    push_instr("t1.mov", 3'b100, 8'h00, 16'd0);
    push_instr("t1.add", 3'b100, 8'h01, 16'd1);
    push_instr("t1.hlt", 3'b000, 8'h02, 16'd2);
    push_state("t1.halt", 3'd5, 8'h02, 16'd3, 3);
    drain(15);
    check("t1.ir", 32'(bus.ir), 32'h7800);

    // Unconditional jump, then hlt at the target.
    fill_rom();
    rom[0] = 15'h6025;
    do_reset();
    bus.run = 1'b1;
    push_instr("t2.jmp", 3'b000, 8'h00, 16'd0);
    push_instr("t2.hlt", 3'b000, 8'h25, 16'd1);
    push_state("t2.halt", 3'd5, 8'h25, 16'd2, 2);
    drain(10);

    // cmp then je 0x40, flag taken.
    fill_rom();
    rom[0] = 15'h5000; rom[1] = 15'h5840;
    cmp_result = 1'b1;
    do_reset();
    bus.run = 1'b1;
    push_instr("t3a.cmp", 3'b001, 8'h00, 16'd0);
    push_instr("t3a.je",  3'b000, 8'h01, 16'd1);
    push_instr("t3a.hlt", 3'b000, 8'h40, 16'd2);
    push_state("t3a.halt", 3'd5, 8'h40, 16'd3, 2);
    drain(14);

    // Same program, flag not set: falls through to address 2.
    cmp_result = 1'b0;
    do_reset();
    bus.run = 1'b1;
    push_instr("t3b.cmp", 3'b001, 8'h00, 16'd0);
    push_instr("t3b.je",  3'b000, 8'h01, 16'd1);
    push_instr("t3b.hlt", 3'b000, 8'h02, 16'd2);
    push_state("t3b.halt", 3'd5, 8'h02, 16'd3, 2);
    drain(14);

    // Store at 0xFF, PC wraps to 0x00.
    fill_rom();
    rom[0] = 15'h60FF; rom[8'hFF] = 15'h7000;
    do_reset();
    bus.run = 1'b1;
    push_instr("t4.jmp", 3'b000, 8'h00, 16'd0);
    drain(4);
    rom[0] = 15'h7800;  // after the wrap, address 0 now halts
    push_instr("t4.st",  3'b010, 8'hFF, 16'd1);
    push_instr("t4.hlt", 3'b000, 8'h00, 16'd2);
    push_state("t4.halt", 3'd5, 8'h00, 16'd3, 2);
    drain(10);

    // RUN dropped in EXEC: add completes, parks in IDLE, resumes at PC 1.
    fill_rom();
    rom[0] = 15'h0800;
    do_reset();
    bus.run = 1'b1;
    push_instr("t5.add", 3'b100, 8'h00, 16'd0);
    push_state("t5.idle", 3'd0, 8'h01, 16'd1, 3);
    drain(3);
    bus.run = 1'b0;
    drain(4);
    bus.run = 1'b1;
    push_instr("t5.hlt", 3'b000, 8'h01, 16'd1);
    push_state("t5.halt", 3'd5, 8'h01, 16'd2, 2);
    drain(6);

    // Reset asserted during WB of an add.
    do_reset();
    bus.run = 1'b1;
    push_instr("t6.add", 3'b100, 8'h00, 16'd0);
    drain(4);
    #1 reset = 1'b1;
    #1;
    check("t6.reg_we", 32'(bus.reg_we), 32'd0);
    check("t6.phase",  32'(bus.phase), 32'd0);
    check("t6.pc",     32'(bus.p_count), 32'd0);
    check("t6.cnt",    32'(bus.inst_cnt), 32'd0);
    @(negedge clk);
    check("t6.held.phase", 32'(bus.phase), 32'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sequencer.md
# sequencer

Instruction sequencer for the 15-bit CPU: owns the program counter and drives `P_COUNT` into the `fetch` block. It latches the returned `PROM_OUT` word into an instruction register and steps each instruction through fixed FETCH/DECODE/EXEC/WB phases. It also issues one-cycle write strobes to the register file, data memory and compare flag, and resolves `jmp`/`je`/`hlt`. It sits between `fetch` and the ALU/register-file datapath.

## Interface
- `PC_W`, 8, program-counter width; equals the `fetch` address width.
- `INST_W`, 15, instruction width; opcode is `[14:11]` and immediate/jump target is `[7:0]`.
- `CLK_SQ`  in  1  system clock; the same clock as `CLK_FT`.
- `RESET`  in  1  asynchronous, active-high reset.
- `RUN`  in  1  level enable; 0 parks the sequencer in IDLE at the next instruction boundary.
- `PROM_OUT`  in  15  instruction word from `fetch`; valid the cycle after `P_COUNT` is stable in FETCH.
- `CMP_EQ`  in  1  ALU equality flag, written by `cmp`.
- `P_COUNT`  out  8  program counter to `fetch`.
- `IR`  out  15  instruction register.
- `PHASE`  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- `REG_WE`  out  1  register-file write strobe.
- `MEM_WE`  out  1  data-memory write strobe.
- `FLAG_WE`  out  1  compare-flag write strobe.
- `HALTED`  out  1  high while in HALT.
- `INST_CNT`  out  16  retired-instruction counter.

## Operation
- Opcode map: 0 mov, 1 add, 2 sub, 3 and, 4 or, 5 sl, 6 sr, 7 sra, 8 ldl, 9 ldh, A cmp, B je, C jmp, D ld, E st, F hlt.
- IDLE -> FETCH when `RUN`=1; otherwise stay in IDLE.
- FETCH -> DECODE, unconditionally. `P_COUNT` is held stable.
- DECODE -> EXEC. On entry to EXEC, `IR` <= `PROM_OUT`.
- EXEC -> WB. The datapath computes from `IR`; the sequencer issues no strobes in EXEC.
- In WB, strobes are issued for one cycle:
  - `REG_WE`=1 for opcodes 0–9 and D.
  - `MEM_WE`=1 for E.
  - `FLAG_WE`=1 for A.
  - B, C and F issue no strobe.
- PC update at the WB->next edge:
  - C: `P_COUNT` <= `IR[7:0]`.
  - B: `P_COUNT` <= `IR[7:0]` if `CMP_EQ`=1 (sampled in WB), else `P_COUNT`+1.
  - F: `P_COUNT` unchanged.
  - All others: `P_COUNT`+1, mod 256 (8'hFF -> 8'h00).
- `INST_CNT` increments by 1 on every WB exit, including `hlt`. It wraps FFFF -> 0000.
- WB exit:
  - Opcode F -> HALT.
  - Else `RUN`=1 -> FETCH.
  - Else -> IDLE.
- HALT is terminal: it is left only through `RESET`. `HALTED`=1 and all strobes stay 0.
- `RUN` falling mid-instruction does not abort; the instruction completes through WB.

## Timing
- Reset values (asynchronous, applied immediately): `PHASE`=IDLE, `P_COUNT`=0, `IR`=0, `REG_WE`=`MEM_WE`=`FLAG_WE`=0, `HALTED`=0, `INST_CNT`=0.
- Every instruction takes exactly 4 cycles, FETCH to WB. There is no pipelining; the next FETCH follows WB directly.
- Instruction period while `RUN`=1 is 4 cycles. From IDLE, the first FETCH is 1 cycle after `RUN` is seen high.
- Strobes are registered outputs, high exactly during the WB cycle and never in any other state.
- `P_COUNT` changes only on the WB-exit edge or on reset.
- A `cmp` followed immediately by a `je`: the flag is written at the `cmp` WB edge, so the `je` sees the new `CMP_EQ` in its WB.
- `RESET` asserted in any state, including mid-WB, drops the strobes combinationally with the flop reset. No partial update of `P_COUNT` or `INST_CNT` may occur.
- A jump target equal to the current PC (a self-loop) is legal and re-fetches the same address.

## Test plan
- Reset and run: `RESET` pulse, `RUN`=1, ROM = {0x0000 mov, 0x0800 add, 0x7800 hlt} -> `P_COUNT` 0,1,2, `REG_WE` pulses in cycles 4 and 8, then `HALTED`=1 from cycle 13. `INST_CNT`=3 and `P_COUNT` stays 2.
- Jump: ROM[0] = 0x6025 (jmp 0x25) -> after the first WB, `P_COUNT`=0x25, no strobe, `INST_CNT`=1.
- Conditional branch: cmp at 0, je 0x40 at 1. With `CMP_EQ`=1, `P_COUNT`=0x40 after the second WB; with `CMP_EQ`=0, it is 2. `FLAG_WE` pulses only in the first WB.
- Store/wrap: `P_COUNT` preloaded to 0xFF via jmp 0xFF; ROM[0xFF] = st (0x7000) -> `MEM_WE` pulses once, `P_COUNT` wraps to 0x00.
- `RUN` gating: drop `RUN` during EXEC -> the instruction completes through WB, then `PHASE`=IDLE. Raising `RUN` again gives FETCH one cycle later with the PC preserved.
- Reset mid-WB: assert `RESET` during the WB of an add -> `REG_WE` is 0 the same cycle, and `P_COUNT`=0, `INST_CNT`=0, `PHASE`=IDLE.
